// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one data RAM port between the core and a DMA/host loader
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   core_* / dma_*      req/we/addr/wdata in; gnt, rvalid pulses and registered rdata out
//   ram_*               registered addr/wdata, one-cycle we/re strobes, rdata RD_LAT after re
//   busy                high whenever the sequencer is not idle
module dram_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int PRIO_CORE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, CAPT, RESP} state_t;
  state_t state, state_nx;
  logic owner;
  logic [1:0] cnt, cnt_nx;
  logic core_win, any_req;
  // owner is 1 for DMA; it doubles as the last-owner flag for round-robin
  assign any_req = core_req | dma_req;
  assign core_win = core_req & (~dma_req | (PRIO_CORE != 0) | owner);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: state_nx = any_req ? ((core_win ? core_we : dma_we) ? WRITE : READ) : IDLE;
      WRITE: state_nx = IDLE;
      READ: begin
        state_nx = RD_LAT > 1 ? WAIT : CAPT;
        cnt_nx = RD_LAT > 1 ? 2'(RD_LAT - 2) : 2'd0;
      end
      WAIT: begin
        state_nx = cnt == 2'd0 ? CAPT : WAIT;
        cnt_nx = cnt - 2'd1;
      end
      CAPT: state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b1;
      cnt <= 2'd0;
      ram_addr <= '0;
      ram_wdata <= '0;
      core_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && any_req) begin
        owner <= ~core_win;
        ram_addr <= core_win ? core_addr : dma_addr;
        ram_wdata <= core_win ? core_wdata : dma_wdata;
      end
      if (state == CAPT && !owner) core_rdata <= ram_rdata;
      if (state == CAPT && owner) dma_rdata <= ram_rdata;
    end
  end
  assign busy = state != IDLE;
  assign ram_we = state == WRITE;
  assign ram_re = state == READ;
  assign core_gnt = (state == WRITE || state == READ) && !owner;
  assign dma_gnt = (state == WRITE || state == READ) && owner;
  assign core_rvalid = state == RESP && !owner;
  assign dma_rvalid = state == RESP && owner;
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Arbitrates the single data RAM port between the processor core and a DMA/host loader port.
- The DMA/host loader port preloads data memory and drains results.
- Sits between the core's data-memory interface and the data RAM; the core sees DRAM through a request/grant/valid handshake instead of driving RAM directly.
- Round-robin or fixed-priority arbitration, a multi-cycle read-latency sequencer, registered RAM control.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- RD_LAT, 2, cycles from the ram_re cycle to the cycle ram_rdata is valid; legal range 1..4.
- PRIO_CORE, 0, 0 = round-robin; 1 = core always wins simultaneous requests.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core access request; held with we/addr/wdata stable until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  one-cycle grant pulse; request accepted and latched.
- core_rvalid  out  1  one-cycle pulse; core_rdata valid.
- core_rdata  out  DATA_W  registered read data; holds until the next core read completes.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same widths and meanings for the DMA port.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_we  out  1  RAM write strobe, one cycle.
- ram_re  out  1  RAM read strobe, one cycle.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the ram_re cycle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: asynchronous. State goes to IDLE. All outputs go to 0: gnts, rvalids, rdatas, ram_addr, ram_wdata, ram_we, ram_re, busy. The last-owner flag is set to DMA, so the core wins the first tie.
- States:
  - IDLE: only state that samples requests.
  - WRITE: 1 cycle.
  - READ: 1 cycle.
  - WAIT: RD_LAT-1 cycles, internal down-counter. Skipped when RD_LAT=1.
  - CAPT: 1 cycle.
  - RESP: 1 cycle.
- Cycle numbering: cycle 0 = IDLE cycle in which a req is high.
- Edge ending cycle 0:
  - Winner selected; owner, we, addr, wdata latched.
  - Winner's gnt=1 during cycle 1.
  - ram_addr/ram_wdata driven from the latched values.
  - State goes to WRITE (ram_we=1) or READ (ram_re=1) for cycle 1.
- Write: cycle 1 is WRITE; IDLE again in cycle 2. Throughput is 1 write per 2 cycles per port.
- Read:
  - Cycle 1: READ.
  - WAIT until cycle RD_LAT.
  - CAPT is cycle 1+RD_LAT: ram_rdata is registered into the owner's rdata at the end of that cycle.
  - Cycle 2+RD_LAT: RESP, owner's rvalid=1.
  - Then IDLE. Read latency req to rvalid = 2+RD_LAT cycles.
- Requester rule: req/we/addr/wdata stay stable until gnt is seen. After the gnt cycle the requester deasserts req or presents a new request. The arbiter ignores req in every non-IDLE state.
- Arbitration (PRIO_CORE=0):
  - Single requester wins.
  - Both requesting: the port that is not the last owner wins.
  - Last owner updates on every grant.
- Arbitration (PRIO_CORE=1): core wins every tie; DMA may starve (accepted).
- A non-granted request stays pending, unlatched, and is re-evaluated in the next IDLE cycle.
- ram_addr/ram_wdata hold their last values when idle. ram_we and ram_re are never both high. Each gnt/rvalid is a single-cycle pulse, and only the owner's signals toggle.
- rdata of the non-owner port is never modified.
- Reset mid-operation (any state): immediate return to IDLE. An in-flight read is discarded: no rvalid is produced, the rdata registers are cleared to 0, and the pending ram_rdata is ignored.
- Out-of-range addresses are not checked; the full ADDR_W is passed through.

Test Plan:
- Write: RD_LAT=2; core_req=1, we=1, addr=0x0005, wdata=0x0401 -> core_gnt=1 in cycle 1; ram_we=1, ram_addr=0x0005, ram_wdata=0x0401 for exactly one cycle; busy=0 in cycle 2.
- Read: core read addr=0x0005; RAM model returns 0x0003 two cycles after ram_re -> ram_re in cycle 1, core_rvalid=1 with core_rdata=0x0003 in cycle 4; dma_rvalid stays 0.
- Round-robin: core and dma both read (addr 0x0002 and 0x0003) from reset, both held until their gnt -> core granted first, dma granted in the IDLE cycle after core's RESP. A second simultaneous pair -> core first again, since the last owner was dma.
- Priority: PRIO_CORE=1, both ports issue 3 back-to-back writes -> all 3 core writes complete before any dma_gnt.
- Reset during WAIT (RD_LAT=4, dma read) -> busy, ram_re and dma_rvalid are 0 immediately; no rvalid pulse afterwards; the next core request is granted normally.
- RD_LAT=1 read of 0x1000 -> WAIT skipped; rvalid in cycle 3 with rdata=0x1000.
